// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared FIR sizing, coefficient type and controller state encoding
// Revision: 1.0
// ============================================================================
package fir_pkg;

  localparam int NTAPS = 16;
  localparam int W     = 16;
  localparam int IDXW  = $clog2(NTAPS);

  typedef logic signed [W-1:0] coef_t;

  localparam coef_t            RST_C0   = 16'sh7FFF;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2,
    SWAP = 2'd3
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_coef_ctrl_if.sv
`default_nettype none
// ============================================================================
// fir_coef_ctrl_if : serial coefficient word stream with valid/ready handshake
// Revision: 1.0
// ============================================================================
interface fir_coef_ctrl_if;
  import fir_pkg::*;

  logic  cfg_valid;
  coef_t cfg_data;
  logic  cfg_last;
  logic  cfg_ready;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_data, input  cfg_last, output cfg_ready);

endinterface
`default_nettype wire

// File: rtl/coef_bank.sv
`default_nettype none
// ============================================================================
// coef_bank : NTAPS x W register array, one indexed write port, parallel read
// Revision: 1.0
// ============================================================================
module coef_bank
  import fir_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [IDXW-1:0] widx_i,
  input  coef_t           wdata_i,
  output coef_t           rdata_o [NTAPS-1:0]
);

  coef_t mem_q [NTAPS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule
`default_nettype wire

// File: rtl/fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// fir_coef_ctrl : loads a coefficient set into a shadow bank and commits it
//                 atomically to the active bank on a sample boundary
// Revision: 1.0
// ============================================================================
module fir_coef_ctrl
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fir_coef_ctrl_if.slave       cfg,
  input  logic                 commit_req_i,
  input  logic                 abort_i,
  input  logic                 sample_en_i,
  output coef_t                coef_o [NTAPS-1:0],
  output logic                 loaded_o,
  output logic                 commit_done_o,
  output logic                 err_len_o,
  output logic                 busy_o
);

  ctrl_state_e     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            loaded_q, loaded_d;
  logic            commit_done_q;
  logic            err_len_q, err_len_d;
  coef_t           active_q [NTAPS-1:0];
  coef_t           shadow [NTAPS-1:0];

  logic            xfer;
  logic            abort_act;
  logic            do_commit;
  logic            shadow_we;
  logic [IDXW-1:0] shadow_widx;

  assign xfer      = cfg.cfg_valid && cfg_ready_q;
  assign abort_act = abort_i && (state_q != IDLE);

  coef_bank u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (shadow_we),
    .widx_i  (shadow_widx),
    .wdata_i (cfg.cfg_data),
    .rdata_o (shadow)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cfg_ready_q   <= 1'b1;
      loaded_q      <= 1'b0;
      commit_done_q <= 1'b0;
      err_len_q     <= 1'b0;
      active_q[0]   <= RST_C0;
      for (int i = 1; i < NTAPS; i++) active_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cfg_ready_q   <= cfg_ready_d;
      loaded_q      <= loaded_d;
      commit_done_q <= do_commit;
      err_len_q     <= err_len_d;
      if (do_commit) begin
        for (int i = 0; i < NTAPS; i++) active_q[i] <= shadow[i];
      end
    end
  end

  // Next-state logic; abort outranks transfers, commit requests and strobes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (xfer && !cfg.cfg_last) begin
          state_d = LOAD;
          idx_d   = IDXW'(1);
        end
      end
      LOAD: begin
        if (abort_act) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = cfg.cfg_last ? PEND : IDLE;
            idx_d   = '0;
          end else if (cfg.cfg_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (abort_act)         state_d = IDLE;
        else if (commit_req_i) state_d = sample_en_i ? IDLE : SWAP;
      end
      SWAP: begin
        if (abort_act)        state_d = IDLE;
        else if (sample_en_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic; a LOAD length error is a cfg_last that disagrees with the final index
  always_comb begin
    shadow_we   = xfer && !abort_act;
    shadow_widx = (state_q == IDLE) ? '0 : idx_q;
    do_commit   = !abort_act &&
                  (((state_q == PEND) && commit_req_i && sample_en_i) ||
                   ((state_q == SWAP) && sample_en_i));
    err_len_d   = 1'b0;
    if (xfer && !abort_act) begin
      if (state_q == IDLE)
        err_len_d = cfg.cfg_last;
      else if (state_q == LOAD)
        err_len_d = (idx_q == LAST_IDX) != cfg.cfg_last;
    end
    cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
    loaded_d    = (state_d == PEND) || (state_d == SWAP);
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign coef_o        = active_q;
  assign loaded_o      = loaded_q;
  assign commit_done_o = commit_done_q;
  assign err_len_o     = err_len_q;
  assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fir_coef_ctrl : directed self-checking bench for fir_coef_ctrl
// Revision: 1.0
// ============================================================================
module tb_fir_coef_ctrl;
  import fir_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  commit_req, abort, sample_en;
  coef_t coef [NTAPS-1:0];
  logic  loaded, commit_done, err_len, busy;

  coef_t exp_coef [NTAPS-1:0];
  int    n_cmp = 0;
  int    n_err = 0;

  fir_coef_ctrl_if cfg_bus ();

  fir_coef_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg_bus.slave),
    .commit_req_i  (commit_req),
    .abort_i       (abort),
    .sample_en_i   (sample_en),
    .coef_o        (coef),
    .loaded_o      (loaded),
    .commit_done_o (commit_done),
    .err_len_o     (err_len),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input coef_t d, input logic last);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_data  = d;
    cfg_bus.cfg_last  = last;
    tick();
  endtask

  task automatic idle_cfg();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_last  = 1'b0;
    cfg_bus.cfg_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < NTAPS; i++) begin
      n_cmp++;
      if (coef[i] !== ((i == 0) ? 16'sh7FFF : 16'sh0000)) begin
        n_err++;
        $display("FAIL reset_coef[%0d]: got %h want %h", i, coef[i], (i == 0) ? 16'h7FFF : 16'h0);
      end
    end
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfg_bus.cfg_ready); end
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (loaded !== 1'b0)      begin n_err++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", commit_done); end
    n_cmp++; if (err_len !== 1'b0)     begin n_err++; $display("FAIL reset_err: got %b want 0", err_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_load_commit();
    for (int i = 0; i < NTAPS; i++) begin
      drive_word(coef_t'(i + 1), i == NTAPS - 1);
      if (i == NTAPS - 2) begin
        n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL full_loaded_early: got %b want 0", loaded); end
      end
    end
    idle_cfg();
    n_cmp++; if (loaded !== 1'b1) begin n_err++; $display("FAIL full_loaded: got %b want 1", loaded); end
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_pend: got %b want 0", cfg_bus.cfg_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick(); tick();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL full_done_early: got %b want 0", commit_done); end
    n_cmp++; if (coef[0] !== 16'sh7FFF) begin n_err++; $display("FAIL full_coef_hold: got %h want 7fff", coef[0]); end
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", commit_done); end
    n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL full_loaded_clr: got %b want 0", loaded); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_clr: got %b want 0", busy); end
    for (int i = 0; i < NTAPS; i++) begin
      exp_coef[i] = coef_t'(i + 1);
      n_cmp++;
      if (coef[i] !== exp_coef[i]) begin
        n_err++;
        $display("FAIL full_coef[%0d]: got %h want %h", i, coef[i], exp_coef[i]);
      end
    end
    tick();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL full_done_pulse: got %b want 0", commit_done); end
  endtask

  task automatic test_short_set();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive_word(coef_t'(100 + i), i == 9);
      if (err_len === 1'b1) pulses++;
    end
    idle_cfg();
    n_cmp++; if (err_len !== 1'b1) begin n_err++; $display("FAIL short_err: got %b want 1", err_len); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL short_busy: got %b want 0", busy); end
    tick();
    if (err_len === 1'b1) pulses++;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL short_pulses: got %0d want 1", pulses); end
    for (int i = 0; i < NTAPS; i++) begin
      n_cmp++;
      if (coef[i] !== exp_coef[i]) begin n_err++; $display("FAIL short_coef[%0d]: got %h want %h", i, coef[i], exp_coef[i]); end
    end
  endtask

  task automatic test_long_set();
    for (int i = 0; i < NTAPS; i++) begin
      drive_word(coef_t'(200 + i), 1'b0);
      if (i == NTAPS - 2) begin
        n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL long_err_early: got %b want 0", err_len); end
      end
    end
    idle_cfg();
    n_cmp++; if (err_len !== 1'b1) begin n_err++; $display("FAIL long_err: got %b want 1", err_len); end
    n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL long_loaded: got %b want 0", loaded); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL long_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL long_err_pulse: got %b want 0", err_len); end
  endtask

  task automatic test_abort_commit();
    for (int i = 0; i < NTAPS; i++) drive_word(coef_t'(16'h1000 + i), i == NTAPS - 1);
    idle_cfg();
    commit_req = 1'b1; abort = 1'b1; sample_en = 1'b1;
    tick();
    commit_req = 1'b0; abort = 1'b0; sample_en = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL abort_loaded: got %b want 0", loaded); end
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", commit_done); end
    n_cmp++; if (err_len !== 1'b0) begin n_err++; $display("FAIL abort_err: got %b want 0", err_len); end
    tick();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL abort_done_late: got %b want 0", commit_done); end
    for (int i = 0; i < NTAPS; i++) begin
      n_cmp++;
      if (coef[i] !== exp_coef[i]) begin n_err++; $display("FAIL abort_coef[%0d]: got %h want %h", i, coef[i], exp_coef[i]); end
    end
  endtask

  task automatic test_back_to_back();
    drive_word(16'sh0055, 1'b1);
    idle_cfg();
    n_cmp++; if (err_len !== 1'b1) begin n_err++; $display("FAIL single_err: got %b want 1", err_len); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
    for (int i = 0; i < NTAPS; i++) drive_word(-coef_t'(i + 1), i == NTAPS - 1);
    idle_cfg();
    commit_req = 1'b1; sample_en = 1'b1;
    tick();
    commit_req = 1'b0; sample_en = 1'b0;
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", commit_done); end
    for (int i = 0; i < NTAPS; i++) begin
      exp_coef[i] = -coef_t'(i + 1);
      n_cmp++;
      if (coef[i] !== exp_coef[i]) begin n_err++; $display("FAIL b2b_coef[%0d]: got %h want %h", i, coef[i], exp_coef[i]); end
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 8; i++) drive_word(coef_t'(16'h0300 + i), 1'b0);
    idle_cfg();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (coef[0] !== 16'sh7FFF) begin n_err++; $display("FAIL rst_coef0: got %h want 7fff", coef[0]); end
    n_cmp++; if (coef[5] !== 16'sh0000) begin n_err++; $display("FAIL rst_coef5: got %h want 0", coef[5]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cfg_bus.cfg_ready); end
    n_cmp++; if (loaded !== 1'b0) begin n_err++; $display("FAIL rst_loaded: got %b want 0", loaded); end
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NTAPS; i++) drive_word(coef_t'(16'h0A00 + i), i == NTAPS - 1);
    idle_cfg();
    n_cmp++; if (loaded !== 1'b1) begin n_err++; $display("FAIL rst_reload_loaded: got %b want 1", loaded); end
    commit_req = 1'b1; sample_en = 1'b1;
    tick();
    commit_req = 1'b0; sample_en = 1'b0;
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL rst_reload_done: got %b want 1", commit_done); end
    for (int i = 0; i < NTAPS; i++) begin
      exp_coef[i] = coef_t'(16'h0A00 + i);
      n_cmp++;
      if (coef[i] !== exp_coef[i]) begin n_err++; $display("FAIL rst_reload_coef[%0d]: got %h want %h", i, coef[i], exp_coef[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    commit_req = 1'b0; abort = 1'b0; sample_en = 1'b0;
    idle_cfg();
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = (i == 0) ? 16'sh7FFF : 16'sh0000;
    test_reset();
    test_full_load_commit();
    test_short_set();
    test_long_set();
    test_abort_commit();
    test_back_to_back();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
